// File: rtl/lane_collector4_pkg.sv
// Shared lane-collector definitions: lane count, lane index width, lane encodings, lock states.
package lane_collector4_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;

  typedef enum logic [LANE_W-1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    LANE3 = 2'd3
  } lane_e;

  typedef enum logic {
    FREE = 1'b0,
    HELD = 1'b1
  } lock_e;

endpackage

// File: rtl/lane_collector4_lane_fifo.sv
// Per-lane FIFO with a show-ahead head word; pointers wrap modulo DEPTH (power of two).
module lane_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lane_collector4.sv
// Four-lane collector: per-lane FIFOs, round-robin arbiter and grant lock FSM.
// Optional overflow counter port ovf_cnt is enabled by defining COLLECTOR_OVF_CNT_EN.
module lane_collector4
  import lane_collector4_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  output1,
  input  logic [WIDTH-1:0]  output2,
  input  logic [WIDTH-1:0]  output3,
  input  logic [WIDTH-1:0]  output4,
  input  logic [LANE_W-1:0] selector,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [LANE_W-1:0] out_lane,
  output logic              out_valid,
  input  logic              out_ready
`ifdef COLLECTOR_OVF_CNT_EN
  ,
  output logic [7:0]        ovf_cnt
`endif
);

  logic [WIDTH-1:0]  lane_in [LANES];
  logic [WIDTH-1:0]  head    [LANES];
  logic [LANES-1:0]  full;
  logic [LANES-1:0]  empty;
  logic [LANES-1:0]  push;
  logic [LANES-1:0]  pop;

  logic [LANE_W-1:0] rr_ptr;
  logic [LANE_W-1:0] lock_lane;
  logic [LANE_W-1:0] search_lane;
  logic [LANE_W-1:0] grant;
  logic              fire;
  lock_e             lock_q;
  lock_e             lock_d;

  assign lane_in[0] = output1;
  assign lane_in[1] = output2;
  assign lane_in[2] = output3;
  assign lane_in[3] = output4;

  // Readiness uses the current count only, so a full lane never accepts a bypass push.
  assign in_ready = !full[selector];
  assign fire     = out_valid && out_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign push[i] = in_valid && in_ready && (selector == LANE_W'(i)) && !reset;
    assign pop[i]  = fire && (grant == LANE_W'(i)) && !reset;

    lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (lane_in[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .head  (head[i])
    );
  end

  always_comb begin
    logic [LANE_W-1:0] idx;
    logic              found;
    idx         = '0;
    found       = 1'b0;
    search_lane = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      idx = rr_ptr + LANE_W'(k);
      if (!found && !empty[idx]) begin
        found       = 1'b1;
        search_lane = idx;
      end
    end
  end

  // A held grant stays on its lane; that lane cannot drain until it is popped.
  assign grant     = (lock_q == HELD) ? lock_lane : search_lane;
  assign out_valid = |(~empty);
  assign out_lane  = grant;
  assign out_data  = out_valid ? head[grant] : '0;

  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      FREE:    if (out_valid && !out_ready) lock_d = HELD;
      HELD:    if (fire) lock_d = FREE;
      default: lock_d = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q    <= FREE;
      lock_lane <= '0;
      rr_ptr    <= '0;
    end else begin
      lock_q <= lock_d;
      if (lock_q == FREE && lock_d == HELD) lock_lane <= grant;
      if (fire) rr_ptr <= grant + 1'b1;
    end
  end

`ifdef COLLECTOR_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_cnt <= '0;
    end else if (in_valid && !in_ready && ovf_cnt != 8'hFF) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
`endif

endmodule
